// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory-access stage: ALU pass-through or load/store over a req/gnt/rvalid bus
module mem_stage (
  input  logic        req,            // clock
  input  logic        reset,
  input  logic        valid_in,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  output logic        stall_out,
  output logic        data_req_out,
  input  logic        data_gnt_in,
  output logic [31:0] data_addr_out,
  output logic        data_we_out,
  output logic [3:0]  data_be_out,
  output logic [31:0] data_wdata_out,
  input  logic        data_rvalid_in,
  input  logic [31:0] data_rdata_in,
  output logic        valid_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out,
  output logic        misaligned_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic        load_q;
  logic [4:0]  rd_q;
  logic        rd_write_q;

  logic        mem_op;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  assign mem_op    = is_load_in | is_store_in;
  assign stall_out = (state != IDLE);

  // Alignment check and store lane steering for the instruction presented in IDLE
  always_comb begin
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = rs2_value_in;
    case (funct3_in[1:0])
      2'b00: begin
        be_next    = 4'b0001 << result_in[1:0];
        wdata_next = {4{rs2_value_in[7:0]}};
      end
      2'b01: begin
        misaligned = result_in[0];
        be_next    = result_in[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{rs2_value_in[15:0]}};
      end
      default: begin
        misaligned = (result_in[1:0] != 2'b00);
      end
    endcase
  end

  // Load data extraction from the returned word using the captured offset and size
  always_comb begin
    sel_byte  = data_rdata_in[7:0];
    sel_half  = addr_lo_q[1] ? data_rdata_in[31:16] : data_rdata_in[15:0];
    load_data = data_rdata_in;
    case (addr_lo_q)
      2'b00:   sel_byte = data_rdata_in[7:0];
      2'b01:   sel_byte = data_rdata_in[15:8];
      2'b10:   sel_byte = data_rdata_in[23:16];
      default: sel_byte = data_rdata_in[31:24];
    endcase
    case (funct3_q)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_data = {24'b0, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_data = {16'b0, sel_half};
      default: load_data = data_rdata_in;
    endcase
  end

  // Stage FSM: accept in IDLE, hold the bus request until granted, then wait for the response
  always_ff @(posedge req) begin
    if (reset) begin
      state          <= IDLE;
      addr_lo_q      <= 2'b00;
      funct3_q       <= 3'b000;
      load_q         <= 1'b0;
      rd_q           <= 5'd0;
      rd_write_q     <= 1'b0;
      data_req_out   <= 1'b0;
      data_addr_out  <= 32'd0;
      data_we_out    <= 1'b0;
      data_be_out    <= 4'b0000;
      data_wdata_out <= 32'd0;
      valid_out      <= 1'b0;
      rd_out         <= 5'd0;
      rd_write_out   <= 1'b0;
      rd_value_out   <= 32'd0;
      misaligned_out <= 1'b0;
    end else begin
      valid_out      <= 1'b0;
      misaligned_out <= 1'b0;
      rd_write_out   <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (!mem_op) begin
              valid_out    <= 1'b1;
              rd_out       <= rd_in;
              rd_write_out <= rd_write_in && (rd_in != 5'd0);
              rd_value_out <= result_in;
            end else if (misaligned) begin
              valid_out      <= 1'b1;
              misaligned_out <= 1'b1;
              rd_out         <= rd_in;
              rd_value_out   <= 32'd0;
            end else begin
              state          <= REQ;
              data_req_out   <= 1'b1;
              data_addr_out  <= {result_in[31:2], 2'b00};
              data_we_out    <= !is_load_in;
              data_be_out    <= be_next;
              data_wdata_out <= is_load_in ? 32'd0 : wdata_next;
              addr_lo_q      <= result_in[1:0];
              funct3_q       <= funct3_in;
              load_q         <= is_load_in;
              rd_q           <= rd_in;
              rd_write_q     <= rd_write_in;
            end
          end
        end
        REQ: begin
          if (data_gnt_in) begin
            state        <= WAIT;
            data_req_out <= 1'b0;
          end
        end
        WAIT: begin
          if (data_rvalid_in) begin
            state        <= IDLE;
            valid_out    <= 1'b1;
            rd_out       <= rd_q;
            rd_write_out <= load_q && rd_write_q && (rd_q != 5'd0);
            rd_value_out <= load_q ? load_data : 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage: vector table, directed sequences, random ops vs byte-level model
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, is_load_in, is_store_in;
  logic [2:0]  funct3_in;
  logic [31:0] result_in, rs2_value_in;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic        stall_out, data_req_out, data_gnt_in;
  logic [31:0] data_addr_out;
  logic        data_we_out;
  logic [3:0]  data_be_out;
  logic [31:0] data_wdata_out;
  logic        data_rvalid_in;
  logic [31:0] data_rdata_in;
  logic        valid_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] rd_value_out;
  logic        misaligned_out;

  mem_stage dut (
    .req(clk), .reset(reset), .valid_in(valid_in), .is_load_in(is_load_in),
    .is_store_in(is_store_in), .funct3_in(funct3_in), .result_in(result_in),
    .rs2_value_in(rs2_value_in), .rd_in(rd_in), .rd_write_in(rd_write_in),
    .stall_out(stall_out), .data_req_out(data_req_out), .data_gnt_in(data_gnt_in),
    .data_addr_out(data_addr_out), .data_we_out(data_we_out), .data_be_out(data_be_out),
    .data_wdata_out(data_wdata_out), .data_rvalid_in(data_rvalid_in),
    .data_rdata_in(data_rdata_in), .valid_out(valid_out), .rd_out(rd_out),
    .rd_write_out(rd_write_out), .rd_value_out(rd_value_out), .misaligned_out(misaligned_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] bus_mem [64];
  logic [7:0]  ref_mem [256];

  logic        r_valid, r_rdw, r_mis, r_we;
  logic [4:0]  r_rd;
  logic [31:0] r_val, r_addr, r_wdata;
  logic [3:0]  r_be;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rdw;
    logic        exp_rdw;
    logic        exp_mis;
    logic [31:0] exp_val;
    logic        chk_val;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture();
    r_valid = valid_out;
    r_rdw   = rd_write_out;
    r_mis   = misaligned_out;
    r_rd    = rd_out;
    r_val   = rd_value_out;
  endtask

  // Presents one instruction and plays the bus side; results land in the r_* globals
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] res, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic rdw, input int gd, input int rdl);
    logic misal;
    logic [31:0] a0;
    valid_in = 1'b1; is_load_in = ld; is_store_in = st; funct3_in = f3;
    result_in = res; rs2_value_in = rs2; rd_in = rd; rd_write_in = rdw;
    data_gnt_in = 1'b0; data_rvalid_in = 1'b0;
    misal = (f3[1:0] == 2'b01 && res[0]) || (f3[1:0] == 2'b10 && res[1:0] != 2'b00);
    tick();
    if (!(ld || st) || misal) begin
      valid_in = 1'b0;
      check("no_bus_req", {31'b0, data_req_out}, 32'd0);
      capture();
      return;
    end
    check("req_rise", {31'b0, data_req_out}, 32'd1);
    check("no_early_valid", {31'b0, valid_out}, 32'd0);
    a0 = data_addr_out;
    for (int i = 0; i < gd; i++) begin
      data_rvalid_in = 1'($urandom_range(0, 1));
      tick();
      check("req_hold", {31'b0, data_req_out}, 32'd1);
      check("addr_hold", data_addr_out, a0);
      check("stall_req", {31'b0, stall_out}, 32'd1);
    end
    data_rvalid_in = 1'($urandom_range(0, 1));
    data_gnt_in = 1'b1;
    r_addr = data_addr_out; r_be = data_be_out; r_we = data_we_out; r_wdata = data_wdata_out;
    if (r_we) begin
      for (int i = 0; i < 4; i++)
        if (r_be[i]) bus_mem[r_addr[7:2]][i*8 +: 8] = r_wdata[i*8 +: 8];
    end
    tick();
    data_gnt_in = 1'b0; data_rvalid_in = 1'b0;
    check("req_drop", {31'b0, data_req_out}, 32'd0);
    for (int i = 0; i < rdl; i++) begin
      check("stall_wait", {31'b0, stall_out}, 32'd1);
      check("valid_wait", {31'b0, valid_out}, 32'd0);
      tick();
    end
    check("stall_wait", {31'b0, stall_out}, 32'd1);
    data_rvalid_in = 1'b1;
    data_rdata_in = bus_mem[r_addr[7:2]];
    tick();
    data_rvalid_in = 1'b0;
    data_rdata_in = $urandom;
    valid_in = 1'b0;
    check("stall_done", {31'b0, stall_out}, 32'd0);
    capture();
  endtask

  initial begin
    int f3l [5];
    f3l = '{0, 1, 2, 4, 5};
    reset = 1'b1; valid_in = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0;
    funct3_in = 3'b0; result_in = 32'd0; rs2_value_in = 32'd0; rd_in = 5'd0;
    rd_write_in = 1'b0; data_gnt_in = 1'b0; data_rvalid_in = 1'b0; data_rdata_in = 32'd0;
    for (int i = 0; i < 64; i++) bus_mem[i] = 32'd0;

    tick(); tick();
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_req", {31'b0, data_req_out}, 32'd0);
    check("rst_stall", {31'b0, stall_out}, 32'd0);
    check("rst_addr", data_addr_out, 32'd0);
    check("rst_be_we", {27'b0, data_we_out, data_be_out}, 32'd0);
    check("rst_wdata", data_wdata_out, 32'd0);
    check("rst_rd", {26'b0, rd_write_out, rd_out}, 32'd0);
    check("rst_value", rd_value_out, 32'd0);
    check("rst_mis", {31'b0, misaligned_out}, 32'd0);
    reset = 1'b0;

    // single-edge cases: ALU ops and rejected misaligned accesses
    tbl[0] = '{1'b0, 1'b0, 3'b000, 32'h0000_0007, 5'd3,  1'b1, 1'b1, 1'b0, 32'h0000_0007, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 3'b010, 32'hFFFF_FFFF, 5'd0,  1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 3'b111, 32'h1234_5678, 5'd31, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 3'b010, 32'h0000_0006, 5'd4,  1'b1, 1'b0, 1'b1, 32'h0,         1'b0};
    tbl[4] = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 5'd5,  1'b1, 1'b0, 1'b1, 32'h0,         1'b0};
    tbl[5] = '{1'b0, 1'b1, 3'b010, 32'h0000_0002, 5'd6,  1'b1, 1'b0, 1'b1, 32'h0,         1'b0};
    tbl[6] = '{1'b1, 1'b0, 3'b101, 32'h0000_0003, 5'd7,  1'b1, 1'b0, 1'b1, 32'h0,         1'b0};
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].res, 32'h5555_AAAA, tbl[i].rd, tbl[i].rdw, 0, 0);
      check($sformatf("tbl%0d_valid", i), {31'b0, r_valid}, 32'd1);
      check($sformatf("tbl%0d_rdw", i), {31'b0, r_rdw}, {31'b0, tbl[i].exp_rdw});
      check($sformatf("tbl%0d_mis", i), {31'b0, r_mis}, {31'b0, tbl[i].exp_mis});
      check($sformatf("tbl%0d_rd", i), {27'b0, r_rd}, {27'b0, tbl[i].rd});
      if (tbl[i].chk_val) check($sformatf("tbl%0d_val", i), r_val, tbl[i].exp_val);
      check($sformatf("tbl%0d_stall", i), {31'b0, stall_out}, 32'd0);
      tick();
      check($sformatf("tbl%0d_pulse", i), {30'b0, valid_out, misaligned_out}, 32'd0);
    end

    // LB / LBU sign handling on the top byte lane
    bus_mem[0] = 32'h80FF_FF12;
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd9, 1'b1, 0, 0);
    check("lb_addr", r_addr, 32'h0000_1000);
    check("lb_val", r_val, 32'hFFFF_FF80);
    check("lb_rdw", {31'b0, r_rdw}, 32'd1);
    check("lb_we", {31'b0, r_we}, 32'd0);
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'd0, 5'd9, 1'b1, 0, 0);
    check("lbu_val", r_val, 32'h0000_0080);

    // SH with grant withheld for three cycles
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd8, 1'b1, 3, 1);
    check("sh_be", {28'b0, r_be}, 32'h0000_000C);
    check("sh_wdata", r_wdata, 32'hABCD_ABCD);
    check("sh_addr", r_addr, 32'h0000_2000);
    check("sh_we", {31'b0, r_we}, 32'd1);
    check("sh_valid", {31'b0, r_valid}, 32'd1);
    check("sh_rdw", {31'b0, r_rdw}, 32'd0);
    tick();
    check("sh_pulse", {31'b0, valid_out}, 32'd0);

    // Reset while waiting for the response, then a stray rvalid
    valid_in = 1'b1; is_load_in = 1'b1; is_store_in = 1'b0; funct3_in = 3'b010;
    result_in = 32'h0000_0040; rd_in = 5'd10; rd_write_in = 1'b1;
    tick();
    data_gnt_in = 1'b1;
    tick();
    data_gnt_in = 1'b0;
    check("rmid_in_wait", {30'b0, stall_out, data_req_out}, 32'd2);
    reset = 1'b1; valid_in = 1'b0;
    tick();
    reset = 1'b0;
    check("rmid_req", {31'b0, data_req_out}, 32'd0);
    check("rmid_stall", {31'b0, stall_out}, 32'd0);
    data_rvalid_in = 1'b1; data_rdata_in = 32'hCAFE_F00D;
    tick();
    data_rvalid_in = 1'b0;
    check("rmid_stray_valid", {31'b0, valid_out}, 32'd0);
    check("rmid_outs", {26'b0, rd_write_out, rd_out}, 32'd0);
    check("rmid_value", rd_value_out, 32'd0);
    tick();
    check("rmid_idle", {29'b0, valid_out, stall_out, data_req_out}, 32'd0);
    check("rmid_addr", data_addr_out, 32'd0);

    // Back-to-back SW then LW to the same word
    run_op(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0, 1, 0);
    check("b2b_sw_valid", {31'b0, r_valid}, 32'd1);
    check("b2b_sw_be", {28'b0, r_be}, 32'h0000_000F);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 5'd7, 1'b1, 0, 2);
    check("b2b_lw_valid", {31'b0, r_valid}, 32'd1);
    check("b2b_lw_val", r_val, 32'hDEAD_BEEF);
    check("b2b_lw_rdw", {31'b0, r_rdw}, 32'd1);

    // Random mix against a byte-array reference model
    for (int w = 0; w < 64; w++) begin
      bus_mem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[w*4 + b] = bus_mem[w][b*8 +: 8];
    end
    for (int t = 0; t < 150; t++) begin
      int kind, a, nbytes;
      logic ld, st, mis, exp_rdw;
      logic [2:0] f3;
      logic [31:0] res, rs2, exp_val;
      logic [4:0] rd;
      logic rdw;
      kind = $urandom_range(0, 2);
      ld = (kind == 1); st = (kind == 2);
      if (ld) f3 = 3'(f3l[$urandom_range(0, 4)]);
      else if (st) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      res = $urandom; rs2 = $urandom;
      rd = 5'($urandom_range(0, 31)); rdw = 1'($urandom_range(0, 1));
      nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) res = res - (res % nbytes);
      a = int'(res[7:0]);
      mis = (ld || st) && (a % nbytes != 0);
      exp_val = res;
      exp_rdw = !mis && !st && rdw && (rd != 0);
      if (ld && !mis) begin
        exp_val = 0;
        for (int b = 0; b < nbytes; b++) exp_val = exp_val + (32'(ref_mem[a + b]) << (8 * b));
        if (f3 == 3'b000 && exp_val >= 128) exp_val = exp_val - 256;
        if (f3 == 3'b001 && exp_val >= 32768) exp_val = exp_val - 65536;
      end
      if (st && !mis)
        for (int b = 0; b < nbytes; b++) ref_mem[a + b] = 8'((rs2 >> (8 * b)) & 255);
      run_op(ld, st, f3, res, rs2, rd, rdw, $urandom_range(0, 3), $urandom_range(0, 3));
      check($sformatf("rnd%0d_valid", t), {31'b0, r_valid}, 32'd1);
      check($sformatf("rnd%0d_mis", t), {31'b0, r_mis}, {31'b0, mis});
      check($sformatf("rnd%0d_rdw", t), {31'b0, r_rdw}, {31'b0, exp_rdw});
      check($sformatf("rnd%0d_rd", t), {27'b0, r_rd}, {27'b0, rd});
      if (!mis && !st) check($sformatf("rnd%0d_val", t), r_val, exp_val);
      if ((ld || st) && !mis) begin
        check($sformatf("rnd%0d_addr", t), r_addr, res & 32'hFFFF_FFFC);
        check($sformatf("rnd%0d_we", t), {31'b0, r_we}, {31'b0, st});
      end
      if ($urandom_range(0, 2) == 0) begin
        tick();
        check($sformatf("rnd%0d_pulse", t), {31'b0, valid_out}, 32'd0);
      end
    end
    // Final read-back of every word through LW confirms the store lanes
    for (int w = 0; w < 64; w++) begin
      logic [31:0] exp_w;
      exp_w = {ref_mem[w*4 + 3], ref_mem[w*4 + 2], ref_mem[w*4 + 1], ref_mem[w*4]};
      run_op(1'b1, 1'b0, 3'b010, 32'(w * 4), 32'd0, 5'd1, 1'b1, 0, 0);
      check($sformatf("dump%0d", w), r_val, exp_w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
